// File: rtl/ham_scrub_ctrl.sv
// Memory scrubber: walks BASE..LAST, runs each word through an external
// hamFix corrector and writes back any word the corrector changed.
// Ports: clock, reset (async, active-high), start pulse, stop level,
//   busy/done status, mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata memory port,
//   fix_in/fix_out corrector port, err_count, last_err_addr, last_err_flip.
// Optional logging of the last corrected word: define HAM_SCRUB_LOG_EN.
module ham_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0,
  parameter int LAST   = 255,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [14:0]       mem_rdata,
  output logic              mem_wr,
  output logic [14:0]       mem_wdata,
  output logic [14:0]       fix_in,
  input  logic [14:0]       fix_out,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic [14:0]       last_err_flip
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, READ, CAPT, FIX, CHK, WRITE, NEXT, DONE
  } state_t;

  state_t state, nstate;

  logic [ADDR_W-1:0] addr;
  logic [14:0]       raw;
  logic [14:0]       wdata;
  logic [CNT_W-1:0]  cnt;
  logic              differ;
  logic              finish;

  assign differ = (fix_out != raw);
  assign finish = (addr == LAST_A) || stop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = READ;
      READ:    nstate = CAPT;
      CAPT:    nstate = FIX;
      FIX:     nstate = CHK;
      CHK:     nstate = differ ? WRITE : NEXT;
      WRITE:   nstate = NEXT;
      NEXT:    nstate = finish ? DONE : READ;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so that reset
  // removes them at once, mid-cycle.
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign mem_rd = (state == READ);
  assign mem_wr = (state == WRITE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr  <= BASE_A;
      raw   <= '0;
      wdata <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr <= BASE_A;
          cnt  <= '0;
        end
        CAPT:  raw <= mem_rdata;
        CHK:   if (differ) wdata <= fix_out;
        WRITE: if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        NEXT:  if (!finish) addr <= addr + ADDR_W'(1);
        DONE:  addr <= BASE_A;
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = wdata;
  assign fix_in    = raw;
  assign err_count = cnt;

`ifdef HAM_SCRUB_LOG_EN
  logic [ADDR_W-1:0] la;
  logic [14:0]       flip;

  // wdata holds the corrector output captured in CHK, so raw^wdata is
  // exactly the set of bits the corrector flipped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      la   <= '0;
      flip <= '0;
    end else if (state == WRITE) begin
      la   <= addr;
      flip <= raw ^ wdata;
    end
  end

  assign last_err_addr = la;
  assign last_err_flip = flip;
`else
  assign last_err_addr = '0;
  assign last_err_flip = '0;
`endif

endmodule
